// File: rtl/encoder_2to4_pkg.sv
// -----------------------------------------------------------------------------
// encoder_2to4_pkg
//   Shared definitions for the 2-to-4 select decoder and its decode stage.
//   - out_w()     : number of decoded lines for a given select width (2**in_w)
//   - SEL4_IN_W   : select width of the standard 2-to-4 build
//   - SEL4_OUT_W  : decoded width of the standard 2-to-4 build
//   - sel4_t      : one-hot select vector type for the 2-to-4 build
// -----------------------------------------------------------------------------
package encoder_2to4_pkg;

  // Every select value maps onto its own output line, so the decoded width is
  // exactly 2**in_w and no select value can fall out of range.
  function automatic int out_w(input int in_w);
    return 1 << in_w;
  endfunction

  localparam int SEL4_IN_W  = 2;
  localparam int SEL4_OUT_W = out_w(SEL4_IN_W);

  typedef logic [SEL4_OUT_W-1:0] sel4_t;

endpackage

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//   Purely combinational binary-to-one-hot decode: y[i] = (w == i).
//   Ports:
//     w  in   IN_W          binary select
//     y  out  2**IN_W       active-high one-hot decode of w
//   A select carrying X/Z in simulation matches no line, so y is all zeros
//   rather than multi-hot. Synthesis treats that case as don't-care.
// -----------------------------------------------------------------------------
module onehot_dec
  import encoder_2to4_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]        w,
  output logic [out_w(IN_W)-1:0] y
);

  localparam int OUT_W = out_w(IN_W);

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves y unassigned would infer a latch.
    y = '0;
    for (int i = 0; i < OUT_W; i++) begin
      // An unknown compare result takes the implicit else path, so an X/Z
      // select leaves y at its all-zero default.
      if (w == IN_W'(i)) begin
        y[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_2to4.sv
// -----------------------------------------------------------------------------
// encoder_2to4
//   Binary-to-one-hot line decoder: the IN_W-bit select W drives exactly one of
//   OUT_W = 2**IN_W output lines. Used as a select/enable generator for muxes,
//   chip selects and register-bank strobes.
//   Parameters:
//     IN_W     select width (OUT_W derived, not overridable)
//     REG_OUT  1: Y registered, 1-cycle latency; 0: Y combinational from W
//     ACT_LOW  0: selected line high; 1: all lines inverted (selected low)
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      synchronous active-low reset (Y forced all-inactive)
//     W      in   IN_W   binary select
//     Y      out  OUT_W  one-hot (one-cold when ACT_LOW) decode of W
// -----------------------------------------------------------------------------
module encoder_2to4
  import encoder_2to4_pkg::*;
#(
  parameter int IN_W    = SEL4_IN_W,
  parameter bit REG_OUT = 1'b1,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        W,
  output logic [out_w(IN_W)-1:0] Y
);

  localparam int OUT_W = out_w(IN_W);

  // Output pattern with no line selected; XOR with it applies the polarity.
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACT_LOW}};

  logic [OUT_W-1:0] raw;

  onehot_dec #(
    .IN_W (IN_W)
  ) u_dec (
    .w (W),
    .y (raw)
  );

  if (REG_OUT) begin : g_reg
    logic [OUT_W-1:0] y_q;

    // The register is glitch-free toward downstream strobes. Reset wins over
    // any select change on the same edge, and the first edge after release
    // loads the decode of the current W.
    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of evaluation order.
      if (!rst_n) begin
        y_q <= INACTIVE;
      end else begin
        y_q <= raw ^ INACTIVE;
      end
    end

    assign Y = y_q;

    a_onehot : assert property (@(posedge clk) rst_n |=> $onehot(Y ^ INACTIVE));
    a_reset  : assert property (@(posedge clk) !rst_n |=> (Y == INACTIVE));
  end else begin : g_comb
    // No register: reset gates the output combinationally.
    assign Y = rst_n ? (raw ^ INACTIVE) : INACTIVE;

    a_onehot : assert property (@(posedge clk) rst_n |-> $onehot(Y ^ INACTIVE));
    a_reset  : assert property (@(posedge clk) !rst_n |-> (Y == INACTIVE));
  end

endmodule

// File: tb/tb_encoder_2to4.sv
// -----------------------------------------------------------------------------
// tb_encoder_2to4
//   Drives three builds of encoder_2to4 side by side:
//     u_reg   default (registered, active-high)
//     u_low   registered, ACT_LOW=1
//     u_comb  REG_OUT=0, with its own select so it can change mid-cycle
//   Expected values come from a reference model: the selected line is 1 << W,
//   the registered builds show the value captured at the last rising edge,
//   and reset shows no line selected.
// -----------------------------------------------------------------------------
module tb_encoder_2to4;
  import encoder_2to4_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] w;
  logic [1:0] w_c;
  sel4_t      y_reg;
  sel4_t      y_low;
  sel4_t      y_comb;

  int checks   = 0;
  int failures = 0;

  // Model state: the active-high value captured at the most recent edge.
  sel4_t exp_q;

  encoder_2to4 #(.IN_W(2), .REG_OUT(1'b1), .ACT_LOW(1'b0)) u_reg (
    .clk (clk), .rst_n (rst_n), .W (w), .Y (y_reg)
  );

  encoder_2to4 #(.IN_W(2), .REG_OUT(1'b1), .ACT_LOW(1'b1)) u_low (
    .clk (clk), .rst_n (rst_n), .W (w), .Y (y_low)
  );

  encoder_2to4 #(.IN_W(2), .REG_OUT(1'b0), .ACT_LOW(1'b0)) u_comb (
    .clk (clk), .rst_n (rst_n), .W (w_c), .Y (y_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input sel4_t got, input sel4_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: selected line is the power of two 2**sel.
  function automatic sel4_t model(input int sel, input bit active);
    return active ? sel4_t'(1 << sel) : sel4_t'(0);
  endfunction

  // One clock: update the model at the rising edge from the inputs that were
  // stable across it, then check every build at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    exp_q = model(int'(w), rst_n);
    @(negedge clk);
    check({tag, "_reg"}, y_reg, exp_q);
    check({tag, "_low"}, y_low, ~exp_q);
    check({tag, "_comb"}, y_comb, model(int'(w_c), rst_n));
  endtask

  initial begin
    sel4_t seq[4];

    rst_n = 1'b0;
    w     = 2'd3;
    w_c   = 2'd0;
    exp_q = '0;

    // Reset held for two edges with W=3: all lines inactive throughout.
    for (int i = 0; i < 2; i++) begin
      cycle("reset");
      check("reset_zero", y_reg, 4'b0000);
      check("reset_low_ones", y_low, 4'b1111);
    end

    // Release: first edge loads the decode of W=3.
    rst_n = 1'b1;
    cycle("release");
    check("release_y", y_reg, 4'b1000);

    // Sweep every select value, one cycle each.
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int s = 0; s < 4; s++) begin
      w = 2'(s);
      cycle("sweep");
      check("sweep_table", y_reg, seq[s]);
    end

    // Back-to-back changes every cycle; never more than one line set.
    for (int k = 0; k < 4; k++) begin
      w = (k % 2 == 0) ? 2'd3 : 2'd0;
      cycle("b2b");
      check("b2b_table", y_reg, (k % 2 == 0) ? 4'b1000 : 4'b0001);
      check("b2b_onehot", sel4_t'($onehot(y_reg)), 4'b0001);
    end

    // Reset for one edge in the middle of a steady W=2 stream.
    w = 2'd2;
    cycle("steady");
    rst_n = 1'b0;
    cycle("mid_rst");
    check("mid_rst_y", y_reg, 4'b0000);
    rst_n = 1'b1;
    cycle("mid_rel");
    check("mid_rel_y", y_reg, 4'b0100);

    // Active-low build with W=1.
    w = 2'd1;
    cycle("low");
    check("low_w1", y_low, 4'b1101);

    // Combinational build: W changes mid-cycle, no clock edge in between.
    w_c = 2'd0;
    #1;
    check("comb_w0", y_comb, 4'b0001);
    w_c = 2'd2;
    #1;
    check("comb_w2", y_comb, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("comb_rst", y_comb, 4'b0000);
    rst_n = 1'b1;
    #1;
    check("comb_rel", y_comb, 4'b0100);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      w     = 2'($urandom_range(0, 3));
      w_c   = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 15) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
